fib_mem_master: RTL and testbench

Bus initiator for the Fibonacci design's single-port synchronous RAM. It drives the RAM's addr/data/cs/we/oe bus. On `start` it writes F(0)…F(N-1) to addresses 0…N-1. When idle it serves single-word read requests from the RAM and returns the captured data. The RAM responds only; this block owns every bus cycle and the tri-state turnaround.

---
 rtl/fib_mem_pkg.sv | 24 ++
 rtl/fib_seq_gen.sv | 42 ++++
 rtl/fib_mem_master.sv | 169 ++++++++++++++++
 tb/tb_fib_mem_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fib_mem_pkg.sv
// Shared types for the Fibonacci RAM master: FSM state encoding and the
// cs/we/oe bus-mode triples driven onto the RAM control pins.
package fib_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    DONE    = 3'd4
  } fib_mem_state_t;

  typedef struct packed {
    logic cs;
    logic we;
    logic oe;
  } bus_mode_t;

  // Field order is {cs, we, oe}
  localparam bus_mode_t BUS_IDLE  = 3'b000;
  localparam bus_mode_t BUS_WRITE = 3'b110;
  localparam bus_mode_t BUS_READ  = 3'b101;

endpackage

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: a/b pair with a modular adder; term is the
// current term a, carry flags that a+b wrapped.
module fib_seq_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] term,
  output logic                  carry
);

  localparam logic [DATA_WIDTH-1:0] TERM_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] TERM_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH:0]   sum_s;

  assign sum_s = {1'b0, a_r} + {1'b0, b_r};
  assign term  = a_r;
  assign carry = sum_s[DATA_WIDTH];

  // Term pair: load seeds F(0)/F(1), step advances one term
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= TERM_ZERO;
      b_r <= TERM_ONE;
    end else if (load) begin
      a_r <= TERM_ZERO;
      b_r <= TERM_ONE;
    end else if (step) begin
      a_r <= b_r;
      b_r <= sum_s[DATA_WIDTH-1:0];
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

endmodule

// File: rtl/fib_mem_master.sv
// RAM bus initiator: fills F(0)..F(N-1) on start, serves single-word reads
// when idle, and owns the mem_data tri-state turnaround.
module fib_mem_master
  import fib_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  localparam logic [ADDR_WIDTH:0]   IDX_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   IDX_TWO   = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH:0]   N_MAX     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  fib_mem_state_t        state_r, next_s;
  logic [ADDR_WIDTH:0]   idx_r, idx_nxt_s;
  logic [ADDR_WIDTH:0]   n_r, n_nxt_s, cnt_sat_s;
  logic                  ovf_r, ovf_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_addr_r, rd_addr_nxt_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, addr_nxt_s;
  bus_mode_t             bus_r, bus_nxt_s;
  logic                  busy_r, done_r, rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  load_s, step_s, carry_s;
  logic [DATA_WIDTH-1:0] term_s;

  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] c);
    return (c > N_MAX) ? N_MAX : c;
  endfunction

  assign cnt_sat_s = sat_count(count);

  fib_seq_gen #(.DATA_WIDTH(DATA_WIDTH)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .step  (step_s),
    .term  (term_s),
    .carry (carry_s)
  );

  // Next-state, counter and sequencer control
  always_comb begin
    next_s        = state_r;
    load_s        = 1'b0;
    step_s        = 1'b0;
    idx_nxt_s     = idx_r;
    n_nxt_s       = n_r;
    ovf_nxt_s     = ovf_r;
    rd_addr_nxt_s = rd_addr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s    = 1'b1;
          idx_nxt_s = IDX_ZERO;
          n_nxt_s   = cnt_sat_s;
          ovf_nxt_s = 1'b0;
          next_s    = (cnt_sat_s == IDX_ZERO) ? DONE : WRITE;
        end else if (rd_req) begin
          rd_addr_nxt_s = rd_addr;
          next_s        = RD_ADDR;
        end else begin
          next_s = IDLE;
        end
      end
      WRITE: begin
        step_s    = 1'b1;
        idx_nxt_s = idx_r + IDX_ONE;
        // The sum a+b becomes term idx+2; only count its wrap if it gets written
        ovf_nxt_s = ovf_r | (carry_s & ((idx_r + IDX_TWO) < n_r));
        next_s    = ((idx_r + IDX_ONE) < n_r) ? WRITE : DONE;
      end
      RD_ADDR: next_s = RD_CAP;
      RD_CAP:  next_s = IDLE;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Bus values for the state being entered, so they come out registered
  always_comb begin
    bus_nxt_s  = BUS_IDLE;
    addr_nxt_s = ADDR_ZERO;
    case (next_s)
      WRITE: begin
        bus_nxt_s  = BUS_WRITE;
        addr_nxt_s = idx_nxt_s[ADDR_WIDTH-1:0];
      end
      RD_ADDR, RD_CAP: begin
        bus_nxt_s  = BUS_READ;
        addr_nxt_s = rd_addr_nxt_s;
      end
      default: begin
        bus_nxt_s  = BUS_IDLE;
        addr_nxt_s = ADDR_ZERO;
      end
    endcase
  end

  // Control state, counters and registered bus/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= IDX_ZERO;
      n_r        <= IDX_ZERO;
      ovf_r      <= 1'b0;
      rd_addr_r  <= ADDR_ZERO;
      bus_r      <= BUS_IDLE;
      mem_addr_r <= ADDR_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_s;
      idx_r      <= idx_nxt_s;
      n_r        <= n_nxt_s;
      ovf_r      <= ovf_nxt_s;
      rd_addr_r  <= rd_addr_nxt_s;
      bus_r      <= bus_nxt_s;
      mem_addr_r <= addr_nxt_s;
      busy_r     <= (next_s != IDLE);
      done_r     <= (next_s == DONE);
    end
  end

  // Read capture: RAM word is sampled at the end of RD_CAP
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= DATA_ZERO;
      rd_valid_r <= 1'b0;
    end else if (state_r == RD_CAP) begin
      rd_data_r  <= mem_data;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign mem_data = bus_r.we ? term_s : {DATA_WIDTH{1'bz}};
  assign mem_cs   = bus_r.cs;
  assign mem_we   = bus_r.we;
  assign mem_oe   = bus_r.oe;
  assign mem_addr = mem_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_fib_mem_master.sv
// Self-checking bench for fib_mem_master with a behavioural synchronous RAM
// and a reference model of the Fibonacci fill and of the RAM contents.
module tb_fib_mem_master;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, rd_req;
  logic [AW:0]   count;
  logic [AW-1:0] rd_addr;
  logic          busy, done, overflow, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fib_mod [0:511];
  int            fib_cap [0:511];
  logic [DW-1:0] shadow  [0:255];

  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_q;

  fib_mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy),
    .done(done), .overflow(overflow), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: registered read, drives data only when oe
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    else if (mem_cs && mem_oe) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};

  // Bus contention watch on every cycle
  always @(negedge clk) begin
    checks++;
    if (mem_we === 1'b1 && mem_oe === 1'b1) begin
      failures++;
      $display("FAIL bus_contention t=%0t we=%b oe=%b required not both 1", $time, mem_we, mem_oe);
    end
  end

  function automatic bit exp_ovf(input int n);
    for (int i = 0; i < n; i++) if (fib_cap[i] >= (1 << DW)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat_n(input int c);
    return (c > (1 << AW)) ? (1 << AW) : c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== 8'd0 || mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0 ||
        mem_addr !== 8'd0) begin
      failures++;
      $display("FAIL reset_values busy=%b done=%b ovf=%b rdv=%b rdd=%0d cs=%b we=%b oe=%b addr=%0d required all 0",
               busy, done, overflow, rd_valid, rd_data, mem_cs, mem_we, mem_oe, mem_addr);
    end
    rst = 1'b0;
  endtask

  // Fill of cnt terms; optionally a simultaneous read and a mid-fill start+read
  task automatic test_fill(input int cnt, input bit with_rd, input int inject_at);
    int n;
    n = sat_n(cnt);
    start = 1'b1; count = cnt[AW:0]; rd_req = with_rd; rd_addr = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    start = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== AW'(i) ||
          mem_data !== fib_mod[i] || busy !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL fill_write n=%0d i=%0d got cs=%b we=%b oe=%b addr=%0d data=%0d busy=%b done=%b rdv=%b required addr=%0d data=%0d",
                 n, i, mem_cs, mem_we, mem_oe, mem_addr, mem_data, busy, done, rd_valid, i, fib_mod[i]);
      end
      if (i == inject_at) begin
        start = 1'b1; count = 9'd3; rd_req = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; rd_req = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_cs !== 1'b0 || mem_we !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_done n=%0d got done=%b busy=%b cs=%b we=%b rdv=%b required done=1 busy=1 cs=0 we=0 rdv=0",
               n, done, busy, mem_cs, mem_we, rd_valid);
    end
    checks++;
    if (overflow !== exp_ovf(n)) begin
      failures++;
      $display("FAIL fill_overflow n=%0d got %b required %b", n, overflow, exp_ovf(n));
    end
    for (int i = 0; i < n; i++) shadow[i] = fib_mod[i];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_cs !== 1'b0) begin
      failures++;
      $display("FAIL fill_idle n=%0d got done=%b busy=%b cs=%b required 0 0 0", n, done, busy, mem_cs);
    end
  endtask

  task automatic test_read(input int addr);
    logic [DW-1:0] expv;
    expv = shadow[addr];
    rd_req = 1'b1; rd_addr = AW'(addr);
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_oe !== 1'b1 || mem_addr !== AW'(addr) ||
          rd_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL read_bus addr=%0d c=%0d got cs=%b we=%b oe=%b maddr=%0d rdv=%b busy=%b required 1 0 1 %0d 0 1",
                 addr, c, mem_cs, mem_we, mem_oe, mem_addr, rd_valid, busy, addr);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== expv || mem_cs !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL read_data addr=%0d got rdv=%b data=%0d cs=%b busy=%b required rdv=1 data=%0d cs=0 busy=0",
               addr, rd_valid, rd_data, mem_cs, busy, expv);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== expv) begin
      failures++;
      $display("FAIL read_hold addr=%0d got rdv=%b data=%0d required rdv=0 data=%0d", addr, rd_valid, rd_data, expv);
    end
  endtask

  task automatic test_sticky_overflow();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky got %b required 1", overflow);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit saw_done;
    start = 1'b1; count = 9'd14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (mem_addr !== 8'd5 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL abort_position got addr=%0d we=%b required addr=5 we=1", mem_addr, mem_we);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0 || rd_data !== 8'd0) begin
      failures++;
      $display("FAIL abort_bus got cs=%b we=%b oe=%b busy=%b done=%b ovf=%b rdd=%0d required all 0",
               mem_cs, mem_we, mem_oe, busy, done, overflow, rd_data);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || mem_cs === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done got done/cs activity=1 required 0");
    end
    test_read(4);
  endtask

  initial begin
    int a, b;
    rst = 1'b1; start = 1'b0; rd_req = 1'b0; count = 9'd0; rd_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'd0;
      shadow[i] = 8'd0;
    end
    ram_q = 8'd0;
    fib_mod[0] = 8'd0; fib_mod[1] = 8'd1;
    fib_cap[0] = 0;    fib_cap[1] = 1;
    for (int i = 2; i < 512; i++) begin
      a = fib_mod[i-1]; b = fib_mod[i-2];
      fib_mod[i] = 8'((a + b) % 256);
      fib_cap[i] = (fib_cap[i-1] + fib_cap[i-2] > 100000) ? 100000 : fib_cap[i-1] + fib_cap[i-2];
    end

    test_reset();
    test_fill(14, 1'b0, -1);
    test_read(12);
    repeat (2) test_read($urandom_range(0, 13));
    test_fill(15, 1'b0, -1);
    test_read(14);
    test_sticky_overflow();
    test_fill(0, 1'b0, -1);
    test_reset_mid_fill();
    test_fill(300, 1'b1, 40);
    test_read(255);
    repeat (4) begin
      test_fill($urandom_range(0, 300), 1'($urandom_range(0, 1)), $urandom_range(0, 20));
      repeat (2) test_read($urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
